uart_irq_arbiter: RTL and testbench



---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_prio_enc.sv | 25 ++
 rtl/uart_irq_arbiter.sv | 125 ++++++++++++
 tb/tb_uart_irq_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: interrupt arbiter FSM state encoding.
package uart_pkg;

  // Arbiter is either waiting for pending work or holding one request open.
  typedef enum logic [0:0] {
    IRQ_ARB_IDLE = 1'b0,
    IRQ_ARB_REQ  = 1'b1
  } uart_irq_arb_state_t;

endpackage : uart_pkg

// File: rtl/uart_prio_enc.sv
// Combinational lowest-index-first priority encoder.
// Index 0 has the highest priority; o_idx is 0 when nothing is set.
module uart_prio_enc #(
  parameter int EVENTS_NUM = 32,
  localparam int ID_W = $clog2(EVENTS_NUM)
) (
  input  logic [EVENTS_NUM-1:0] i_req,
  output logic                  o_valid,
  output logic [ID_W-1:0]       o_idx
);

  // Scan from the top down so the lowest set index is the last to win.
  always_comb begin
    o_valid = |i_req;
    o_idx   = {ID_W{1'b0}};
    for (int i = EVENTS_NUM - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = ID_W'(i);
      end else begin
        o_idx = o_idx;
      end
    end
  end

endmodule : uart_prio_enc

// File: rtl/uart_irq_arbiter.sv
// UART interrupt arbiter: captures IRQ rising edges into a pending
// register, serializes them as one req/ack transaction at a time, and
// returns a one-cycle disable pulse per acknowledged or cleared event.
module uart_irq_arbiter #(
  parameter int EVENTS_NUM = 32,
  localparam int ID_W = $clog2(EVENTS_NUM)
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_arb_en,
  input  logic [EVENTS_NUM-1:0] i_irq_bus,
  input  logic [EVENTS_NUM-1:0] i_sw_clear,
  input  logic                  i_ack,
  output logic                  o_req,
  output logic [ID_W-1:0]       o_irq_id,
  output logic [EVENTS_NUM-1:0] o_pending,
  output logic [EVENTS_NUM-1:0] o_events_disable
);

  import uart_pkg::*;

  localparam logic [EVENTS_NUM-1:0] ONE_HOT_BASE = {{(EVENTS_NUM-1){1'b0}}, 1'b1};

  logic [EVENTS_NUM-1:0] irq_prev_q, irq_prev_d;
  logic [EVENTS_NUM-1:0] pending_q, pending_d;
  logic [EVENTS_NUM-1:0] disable_q, disable_d;
  uart_irq_arb_state_t   state_q, state_d;
  logic                  req_q, req_d;
  logic [ID_W-1:0]       irq_id_q, irq_id_d;

  logic [EVENTS_NUM-1:0] rise_s;
  logic [EVENTS_NUM-1:0] ack_mask_s;
  logic                  ack_hit_s;
  logic                  retract_s;
  logic                  enc_valid_s;
  logic [ID_W-1:0]       enc_idx_s;

  uart_prio_enc #(
    .EVENTS_NUM(EVENTS_NUM)
  ) u_prio_enc (
    .i_req  (pending_q),
    .o_valid(enc_valid_s),
    .o_idx  (enc_idx_s)
  );

  // Edge capture and pending update; a new rise beats any clear of the same bit.
  always_comb begin
    irq_prev_d = i_irq_bus;
    rise_s     = i_irq_bus & ~irq_prev_q;
    ack_hit_s  = (state_q == IRQ_ARB_REQ) && i_ack;
    retract_s  = (state_q == IRQ_ARB_REQ) && !i_ack && i_sw_clear[irq_id_q];
    if (ack_hit_s) begin
      ack_mask_s = ONE_HOT_BASE << irq_id_q;
    end else begin
      ack_mask_s = {EVENTS_NUM{1'b0}};
    end
    pending_d = rise_s | (pending_q & ~i_sw_clear & ~ack_mask_s);
    disable_d = ack_mask_s | i_sw_clear;
  end

  // Request FSM next state: open on lowest pending, close on ack or retract.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    irq_id_d = irq_id_q;
    case (state_q)
      IRQ_ARB_IDLE: begin
        if (i_arb_en && enc_valid_s) begin
          state_d  = IRQ_ARB_REQ;
          req_d    = 1'b1;
          irq_id_d = enc_idx_s;
        end else begin
          state_d  = IRQ_ARB_IDLE;
          req_d    = 1'b0;
        end
      end
      IRQ_ARB_REQ: begin
        if (ack_hit_s || retract_s) begin
          state_d = IRQ_ARB_IDLE;
          req_d   = 1'b0;
        end else begin
          state_d = IRQ_ARB_REQ;
          req_d   = 1'b1;
        end
      end
      default: begin
        state_d  = IRQ_ARB_IDLE;
        req_d    = 1'b0;
        irq_id_d = {ID_W{1'b0}};
      end
    endcase
  end

  // Capture, pending and disable-pulse registers.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      irq_prev_q <= {EVENTS_NUM{1'b0}};
      pending_q  <= {EVENTS_NUM{1'b0}};
      disable_q  <= {EVENTS_NUM{1'b0}};
    end else begin
      irq_prev_q <= irq_prev_d;
      pending_q  <= pending_d;
      disable_q  <= disable_d;
    end
  end

  // FSM state and its registered request outputs.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q  <= IRQ_ARB_IDLE;
      req_q    <= 1'b0;
      irq_id_q <= {ID_W{1'b0}};
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      irq_id_q <= irq_id_d;
    end
  end

  assign o_req            = req_q;
  assign o_irq_id         = irq_id_q;
  assign o_pending        = pending_q;
  assign o_events_disable = disable_q;

endmodule : uart_irq_arbiter

// File: tb/tb_uart_irq_arbiter.sv
// Scoreboard bench for uart_irq_arbiter: a driver applies directed and
// random stimulus, steps a behavioural model and queues the expected
// post-edge state; a negedge monitor pops and compares it.
module tb_uart_irq_arbiter;

  localparam int N = 32;

  logic          i_clk = 1'b0;
  logic          i_nrst;
  logic          i_arb_en;
  logic [N-1:0]  i_irq_bus;
  logic [N-1:0]  i_sw_clear;
  logic          i_ack;
  logic          o_req;
  logic [4:0]    o_irq_id;
  logic [N-1:0]  o_pending;
  logic [N-1:0]  o_events_disable;

  uart_irq_arbiter #(.EVENTS_NUM(N)) dut (
    .i_clk           (i_clk),
    .i_nrst          (i_nrst),
    .i_arb_en        (i_arb_en),
    .i_irq_bus       (i_irq_bus),
    .i_sw_clear      (i_sw_clear),
    .i_ack           (i_ack),
    .o_req           (o_req),
    .o_irq_id        (o_irq_id),
    .o_pending       (o_pending),
    .o_events_disable(o_events_disable)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic         req;
    logic [4:0]   id;
    logic [N-1:0] pend;
    logic [N-1:0] dis;
  } snap_t;

  snap_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Behavioural model state: pending set, disable pulse, open request.
  bit [N-1:0] m_prev, m_pend, m_dis;
  bit         m_busy;
  int         m_id;
  bit [N-1:0] cur_bus;
  bit         cur_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input bit [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_pend = '0; m_dis = '0; m_busy = 1'b0; m_id = 0;
  endtask

  // One clock edge of the arbiter, phrased directly from its rules.
  task automatic model_edge(input bit en, input bit [N-1:0] bus,
                            input bit [N-1:0] clr, input bit ack);
    bit [N-1:0] nxt;
    bit [N-1:0] acked_bit;
    bit         acked;
    acked_bit = '0;
    acked = m_busy && ack;
    if (acked) acked_bit[m_id] = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (bus[i] && !m_prev[i]) nxt[i] = 1'b1;      // new rise always wins
      else if (clr[i])          nxt[i] = 1'b0;
      else if (acked_bit[i])    nxt[i] = 1'b0;
      else                      nxt[i] = m_pend[i];
    end
    m_dis = clr | acked_bit;
    if (m_busy) begin
      if (acked || clr[m_id]) m_busy = 1'b0;
    end else if (en && m_pend != '0) begin
      m_busy = 1'b1;
      m_id   = lowest(m_pend);
    end
    m_pend = nxt;
    m_prev = bus;
  endtask

  // Drive one cycle; optionally pulse the async reset before the edge.
  task automatic cyc(input bit en, input bit [N-1:0] bus, input bit [N-1:0] clr,
                     input bit ack, input bit rst_first);
    snap_t s;
    @(negedge i_clk);
    #1;
    if (rst_first) begin
      i_nrst = 1'b0;
      #1;
      chk("rst_req", 32'(o_req), 32'd0);
      chk("rst_id", 32'(o_irq_id), 32'd0);
      chk("rst_pending", o_pending, 32'd0);
      chk("rst_disable", o_events_disable, 32'd0);
      model_reset();
      #1;
      i_nrst = 1'b1;
    end
    i_arb_en = en; i_irq_bus = bus; i_sw_clear = clr; i_ack = ack;
    cur_bus = bus; cur_en = en;
    model_edge(en, bus, clr, ack);
    s.req = m_busy; s.id = m_id[4:0]; s.pend = m_pend; s.dis = m_dis;
    exp_q.push_back(s);
  endtask

  task automatic idle(input int n, input bit [N-1:0] bus);
    for (int i = 0; i < n; i++) cyc(1'b1, bus, '0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, '0, '0, 1'b1, 1'b0);
  endtask

  // Monitor: compare DUT outputs with the snapshot queued for this edge.
  always @(negedge i_clk) begin
    snap_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("req", 32'(o_req), 32'(e.req));
      chk("pending", o_pending, e.pend);
      chk("disable", o_events_disable, e.dis);
      if (e.req) chk("irq_id", 32'(o_irq_id), 32'(e.id));
    end
  end

  initial begin
    i_nrst = 1'b0; i_arb_en = 1'b0; i_irq_bus = '0; i_sw_clear = '0; i_ack = 1'b0;
    model_reset();
    cur_bus = '0; cur_en = 1'b1;

    // Reset state, then a single event on line 5 held high.
    cyc(1'b1, '0, '0, 1'b0, 1'b1);
    idle(3, 32'h0000_0020);
    cyc(1'b1, 32'h0000_0020, '0, 1'b1, 1'b0);
    idle(2, 32'h0000_0020);
    idle(3, '0);

    // Simultaneous rise on 3, 7, 12: served in index order with gaps.
    idle(3, 32'h0000_1088);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 32'h0000_1088, '0, 1'b1, 1'b0);
      idle(1, 32'h0000_1088);
    end
    idle(3, '0);

    // Software retract of id 4 with id 6 also pending.
    idle(3, 32'h0000_0050);
    cyc(1'b1, 32'h0000_0050, 32'h0000_0010, 1'b0, 1'b0);
    idle(3, 32'h0000_0050);
    cyc(1'b1, 32'h0000_0050, '0, 1'b1, 1'b0);
    idle(3, '0);

    // Rise on 2 collides with a software clear of 2: pending must stay set.
    cyc(1'b1, 32'h0000_0004, 32'h0000_0004, 1'b0, 1'b0);
    idle(2, 32'h0000_0004);
    drain(4);

    // Arbitration disabled while lines 0 and 1 rise, then enabled.
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0000_0003, '0, 1'b0, 1'b0);
    idle(2, 32'h0000_0003);
    cyc(1'b1, 32'h0000_0003, '0, 1'b1, 1'b0);
    idle(2, 32'h0000_0003);
    drain(4);

    // Reset in the middle of a request; line 7 stays high across it.
    idle(3, 32'h0000_00F0);
    cyc(1'b1, 32'h0000_0080, '0, 1'b0, 1'b1);
    idle(3, 32'h0000_0080);
    drain(4);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      bit [N-1:0] bus, clr;
      bit en, ack, rst;
      bus = cur_bus;
      for (int b = 0; b < N; b++) if ($urandom_range(0, 63) == 0) bus[b] = ~bus[b];
      clr = '0;
      if ($urandom_range(0, 15) == 0) clr[$urandom_range(0, N-1)] = 1'b1;
      if (m_busy && $urandom_range(0, 19) == 0) clr[m_id] = 1'b1;
      en = cur_en;
      if ($urandom_range(0, 49) == 0) en = ~en;
      ack = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 499) == 0);
      cyc(en, bus, clr, ack, rst);
    end

    @(negedge i_clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_irq_arbiter
